oam_dma_ctrl: RTL and testbench
===============================

Name: oam_dma_ctrl

Overview:
Sprite DMA engine for the NES CPU/PPU interface. A CPU write to $4014 starts a 256-byte copy from CPU page {data,8'h00} into PPU OAM. While the copy runs, oam_dma is held high; the top level ANDs it into the CPU rdy line to halt the CPU. The block drives its own CPU-bus read requests and PPU OAM writes (oam_addr, oam_data_in, oam_we).

Parameters:
DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA
NUM_BYTES, 256, bytes per transfer (power of two, ≤256)

Ports:
clk  in  1  system clock; all state changes on rising edge
reset  in  1  synchronous, active-high; state returns to IDLE
cpu_addr  in  16  CPU bus address
cpu_data_out  in  8  CPU write data
cpu_we  in  1  CPU write strobe, active-high, one cycle per write
oam_base  in  8  current PPU OAMADDR, sampled at trigger
dma_addr  out  16  DMA read address to CPU memory map
dma_rd  out  1  DMA read request
dma_data_in  in  8  read data, valid the cycle after dma_rd
oam_dma  out  1  DMA active (CPU halted)
oam_addr  out  8  OAM write address
oam_data_in  out  8  OAM write data
oam_we  out  1  OAM write strobe

Behaviour:
- Reset values: oam_dma=0, dma_rd=0, oam_we=0, dma_addr=0, oam_addr=0, oam_data_in=0. All internal registers are cleared, including the parity bit.
- Parity bit odd_cycle: cleared on reset, toggles every clk, free-running.
- Trigger condition: cpu_we=1 and cpu_addr==DMA_REG_ADDR while in IDLE.
- On trigger, latch the following:
  - page ← cpu_data_out
  - base ← oam_base
  - idx ← 0
- A trigger when not in IDLE is ignored. Reads of $4014 never trigger.
- States and transitions:
  - IDLE → HALT on trigger.
  - HALT (1 cycle) → ALIGN if odd_cycle==1 in HALT, else → READ.
  - ALIGN (1 cycle) → READ.
  - READ → WRITE.
  - WRITE → READ if idx≠NUM_BYTES-1, else → IDLE. idx increments on each WRITE exit.
- oam_dma=1 in HALT, ALIGN, READ and WRITE. It is 0 only in IDLE.
- Total active cycles: 513 on even alignment, 514 on odd.
- READ outputs: dma_rd=1, dma_addr={page, idx}. Otherwise dma_rd=0 and dma_addr holds its last value.
- WRITE outputs:
  - oam_we=1
  - oam_addr=(base+idx) mod 256; wraps, no carry
  - oam_data_in=dma_data_in, passed through combinationally
- Outside WRITE: oam_we=0; oam_addr and oam_data_in are don't-care, driven 0.
- Exactly NUM_BYTES oam_we pulses per DMA, never two in consecutive cycles.
- The block ignores cpu_we and cpu_addr while oam_dma=1; the CPU is halted and the bench must not rely on them.
- Reset mid-transfer: next cycle is IDLE with all outputs at reset values. No further oam_we. Already-written OAM bytes remain. A trigger in the same cycle as reset is ignored.
- page=8'hFF: dma_addr spans FF00–FFFF with no special casing.
- Back-to-back: a trigger in the first IDLE cycle after completion starts a new DMA normally.
- Implementation: Moore FSM, single always_ff for state/idx/page/base/parity, always_comb for outputs.

Test Plan:
1. Trigger write 8'h02 to $4014 with odd_cycle=0 in HALT; memory returns addr[7:0]^8'h5A → oam_dma high for exactly 513 cycles. dma_addr runs 0200..02FF. 256 oam_we pulses at oam_addr 0..255 with data k^8'h5A.
2. Same as 1 but triggered one cycle later (odd alignment) → oam_dma high for 514 cycles. First dma_rd occurs 2 cycles after HALT entry; data is otherwise identical.
3. oam_base=8'hF0, page 8'h03 → byte k is written to oam_addr (8'hF0+k)&8'hFF. Writes 0x0F..0x10 wrap to 0xFF then 0x00. dma_addr runs 0300..03FF.
4. Second write to $4014 (data 8'h07) at byte 40 mid-transfer → ignored. dma_addr stays in page 02 through completion. After IDLE, a fresh write of 8'h07 starts page 07.
5. Assert reset during WRITE of byte 100 → next cycle oam_dma=0, oam_we=0, dma_rd=0. No oam_we for the rest of the run. A later trigger produces a full 256-byte copy.
6. Writes to $4015 and $2004, plus cpu_we=0 with cpu_addr=$4014 → no trigger. oam_dma stays 0 for 600 cycles.

Source files
------------

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: NES sprite DMA engine, copies one CPU page into PPU OAM after a write to $4014.
//   clk, reset        : clock, synchronous active-high reset
//   cpu_addr/cpu_data_out/cpu_we : CPU write bus, watched for the trigger write
//   oam_base          : current OAMADDR, latched as the write base at trigger
//   dma_addr/dma_rd   : DMA read request into the CPU memory map
//   dma_data_in       : read data, valid the cycle after dma_rd
//   oam_dma           : high while the transfer runs (halts the CPU)
//   oam_addr/oam_data_in/oam_we : OAM write port
module oam_dma_ctrl #(
   parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
   parameter int          NUM_BYTES    = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data_out,
   input  logic        cpu_we,
   input  logic [7:0]  oam_base,
   output logic [15:0] dma_addr,
   output logic        dma_rd,
   input  logic [7:0]  dma_data_in,
   output logic        oam_dma,
   output logic [7:0]  oam_addr,
   output logic [7:0]  oam_data_in,
   output logic        oam_we
);
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;
   state_t      state, state_nx;
   logic [7:0]  idx, page, base;
   logic [15:0] addr_hold;
   logic        odd_cycle, trigger, last;
   assign trigger = cpu_we && cpu_addr == DMA_REG_ADDR;
   assign last    = idx == 8'(NUM_BYTES - 1);
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = trigger ? HALT : IDLE;
         // an odd halt cycle costs one extra alignment cycle before reading
         HALT:    state_nx = odd_cycle ? ALIGN : READ;
         ALIGN:   state_nx = READ;
         READ:    state_nx = WRITE;
         WRITE:   state_nx = last ? IDLE : READ;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         idx       <= 8'd0;
         page      <= 8'd0;
         base      <= 8'd0;
         addr_hold <= 16'd0;
         odd_cycle <= 1'b0;
      end else begin
         state     <= state_nx;
         odd_cycle <= ~odd_cycle;
         if (state == IDLE && trigger) begin
            page <= cpu_data_out;
            base <= oam_base;
            idx  <= 8'd0;
         end
         // dma_addr keeps showing the last read address between reads
         if (state == READ) addr_hold <= {page, idx};
         if (state == WRITE) idx <= idx + 8'd1;
      end
   end
   always_comb begin
      oam_dma     = state != IDLE;
      dma_rd      = state == READ;
      dma_addr    = dma_rd ? {page, idx} : addr_hold;
      oam_we      = state == WRITE;
      oam_addr    = oam_we ? base + idx : 8'h00;
      oam_data_in = oam_we ? dma_data_in : 8'h00;
   end
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: scoreboard bench for oam_dma_ctrl.
module tb_oam_dma_ctrl;
   logic        clk = 1'b0, reset = 1'b1;
   logic [15:0] cpu_addr = 16'h0;
   logic [7:0]  cpu_data_out = 8'h0, oam_base = 8'h0, dma_data_in = 8'h0;
   logic        cpu_we = 1'b0;
   logic [15:0] dma_addr;
   logic        dma_rd, oam_dma, oam_we;
   logic [7:0]  oam_addr, oam_data_in;
   oam_dma_ctrl dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
      .cpu_we(cpu_we), .oam_base(oam_base), .dma_addr(dma_addr), .dma_rd(dma_rd),
      .dma_data_in(dma_data_in), .oam_dma(oam_dma), .oam_addr(oam_addr),
      .oam_data_in(oam_data_in), .oam_we(oam_we)
   );
   always #5 clk = ~clk;
   int checks = 0, errors = 0;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   // CPU memory model: byte at addr reads back as addr[7:0]^5A one cycle later
   always @(posedge clk) dma_data_in <= dma_rd ? (dma_addr[7:0] ^ 8'h5A) : 8'hEE;
   // reference parity: value during the current cycle
   logic p = 1'b0;
   always @(posedge clk) p <= reset ? 1'b0 : ~p;
   logic [15:0] exp_q[$], addr_q[$];
   int          len_q[$], first_q[$];
   int          run_len = 0, run_we = 0;
   logic        prev_we = 1'b0, rd_seen = 1'b0;
   logic [15:0] e;
   always @(negedge clk) begin
      if (oam_we) begin
         if (prev_we) chk("we_back_to_back", 1, 0);
         if (exp_q.size() == 0) chk("spurious_we", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("oam_addr", 32'(oam_addr), 32'(e[15:8]));
            chk("oam_data", 32'(oam_data_in), 32'(e[7:0]));
         end
         run_we++;
      end
      if (dma_rd) begin
         if (addr_q.size() == 0) chk("spurious_rd", 1, 0);
         else chk("dma_addr", 32'(dma_addr), 32'(addr_q.pop_front()));
      end
      if (oam_dma) begin
         run_len++;
         if (dma_rd && !rd_seen) begin
            rd_seen = 1'b1;
            if (first_q.size() != 0) chk("first_rd_cycle", run_len, first_q.pop_front());
         end
      end else if (run_len != 0) begin
         if (len_q.size() != 0) begin
            chk("active_len", run_len, len_q.pop_front());
            chk("we_per_dma", run_we, 256);
         end
         run_len = 0;
         run_we  = 0;
         rd_seen = 1'b0;
      end
      prev_we = oam_we;
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // par<0: trigger now; otherwise trigger so that the HALT cycle has parity par
   task automatic trig(input logic [7:0] pg, input logic [7:0] bs, input int par);
      int hp;
      if (par >= 0 && p == par[0]) cyc();
      hp = p ? 0 : 1;
      for (int k = 0; k < 256; k++) begin
         exp_q.push_back({8'(bs + 8'(k)), 8'(k) ^ 8'h5A});
         addr_q.push_back({pg, 8'(k)});
      end
      len_q.push_back(513 + hp);
      first_q.push_back(2 + hp);
      cpu_addr = 16'h4014; cpu_data_out = pg; oam_base = bs; cpu_we = 1'b1;
      cyc();
      cpu_we = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while (oam_dma && n < 2000) begin cyc(); n++; end
      if (n >= 2000) chk("idle_timeout", 1, 0);
   endtask
   task automatic wait_we(input int cnt);
      int n = 0;
      while (!(oam_we && run_we == cnt) && n < 2000) begin cyc(); n++; end
      if (n >= 2000) chk("we_timeout", 1, 0);
   endtask
   initial begin
      int hi;
      // trigger held during reset must be ignored
      cpu_addr = 16'h4014; cpu_data_out = 8'h55; cpu_we = 1'b1;
      repeat (3) cyc();
      reset = 1'b0; cpu_we = 1'b0;
      @(negedge clk);
      chk("rst_oam_dma", 32'(oam_dma), 0);
      chk("rst_dma_rd", 32'(dma_rd), 0);
      chk("rst_oam_we", 32'(oam_we), 0);
      chk("rst_dma_addr", 32'(dma_addr), 0);
      chk("rst_oam_addr", 32'(oam_addr), 0);
      chk("rst_oam_data", 32'(oam_data_in), 0);
      cyc();
      // even and odd alignment
      trig(8'h02, 8'h00, 0);
      wait_idle();
      chk("dma_addr_hold", 32'(dma_addr), 32'h02FF);
      repeat (3) cyc();
      trig(8'h02, 8'h00, 1);
      wait_idle();
      repeat (2) cyc();
      // OAM address wrap
      trig(8'h03, 8'hF0, -1);
      wait_idle();
      chk("dma_addr_hold3", 32'(dma_addr), 32'h03FF);
      // mid-transfer trigger ignored, then back-to-back trigger in first IDLE cycle
      trig(8'h02, 8'h00, -1);
      wait_we(40);
      cpu_addr = 16'h4014; cpu_data_out = 8'h07; cpu_we = 1'b1;
      cyc();
      cpu_we = 1'b0;
      wait_idle();
      trig(8'h07, 8'h00, -1);
      wait_idle();
      chk("dma_addr_hold7", 32'(dma_addr), 32'h07FF);
      // page FF
      trig(8'hFF, 8'h10, -1);
      wait_idle();
      // reset during WRITE of byte 100
      trig(8'h02, 8'h00, -1);
      wait_we(100);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      exp_q.delete(); addr_q.delete(); len_q.delete(); first_q.delete();
      @(negedge clk);
      chk("mid_rst_oam_dma", 32'(oam_dma), 0);
      chk("mid_rst_oam_we", 32'(oam_we), 0);
      chk("mid_rst_dma_rd", 32'(dma_rd), 0);
      chk("mid_rst_dma_addr", 32'(dma_addr), 0);
      repeat (50) cyc();
      trig(8'h05, 8'h0A, -1);
      wait_idle();
      // non-trigger accesses
      cpu_data_out = 8'h02;
      cpu_addr = 16'h4015; cpu_we = 1'b1; cyc();
      cpu_addr = 16'h2004; cyc();
      cpu_addr = 16'h4014; cpu_we = 1'b0; cyc();
      hi = 0;
      for (int i = 0; i < 600; i++) begin
         if (oam_dma) hi++;
         cyc();
      end
      chk("no_trigger_cycles", hi, 0);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
